// File: rtl/spi_slave_peripheral.sv
// SPI slave (CPOL=1, 16-bit frames) with a single-word transmit holding register.
// All SPI pins are resynchronised to clk and sampled by edge detection.
module spi_slave_peripheral (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_bar,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StActive, StDone, StRearm} state_e;

  state_e state_q, state_d;

  logic        sclk_meta, sclk_s, sclk_prev;
  logic        cs_meta, cs_s;
  logic        mosi_meta, mosi_s;
  logic        cs_seen_q;
  logic        sclk_rise, sclk_fall;

  logic [15:0] hold_q;
  logic        hold_full_q;
  logic [15:0] load_val;
  logic [15:0] tx_shift_q;
  logic [15:0] rx_shift_q;
  logic [4:0]  bit_cnt_q;
  logic        miso_q, oe_q, busy_q;
  logic [15:0] rx_data_q;
  logic        rx_valid_q, frame_err_q;

  logic start, abort, rx_shift_en, tx_shift_en, finish, release_cs;

  // Synchronisers clear to 0, so cs_bar reads "low" until it has been seen high once;
  // cs_seen_q keeps a frame already in progress at reset release from being accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b0;
      cs_s      <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
      cs_seen_q <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_s    <= sclk_meta;
      sclk_prev <= sclk_s;
      cs_meta   <= cs_bar;
      cs_s      <= cs_meta;
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
      cs_seen_q <= cs_seen_q | cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!cs_s) state_d = cs_seen_q ? StActive : StRearm;
      end
      StActive: begin
        if (cs_s) state_d = StIdle;
        else if (sclk_rise && bit_cnt_q == 5'd15) state_d = StDone;
      end
      StDone:  state_d = StRearm;
      StRearm: begin
        if (cs_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start       = 1'b0;
    abort       = 1'b0;
    rx_shift_en = 1'b0;
    tx_shift_en = 1'b0;
    finish      = 1'b0;
    release_cs  = 1'b0;
    unique case (state_q)
      StIdle:   start = !cs_s && cs_seen_q;
      StActive: begin
        abort       = cs_s;
        rx_shift_en = !cs_s && sclk_rise;
        // Bit 15 is already on miso at frame start, so falling edges 1..15 carry 14..0.
        tx_shift_en = !cs_s && sclk_fall && bit_cnt_q != 5'd0 && bit_cnt_q < 5'd16;
      end
      StDone:   finish = 1'b1;
      StRearm:  release_cs = cs_s;
      default:  ;
    endcase
  end

  assign load_val = hold_full_q ? hold_q : (tx_load ? tx_data : 16'h0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q      <= 16'h0000;
      hold_full_q <= 1'b0;
    end else if (start) begin
      hold_full_q <= 1'b0;
    end else if (tx_load && !hold_full_q) begin
      hold_q      <= tx_data;
      hold_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift_q <= 16'h0000;
      rx_shift_q <= 16'h0000;
      bit_cnt_q  <= 5'd0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else if (start) begin
      tx_shift_q <= load_val;
      bit_cnt_q  <= 5'd0;
      miso_q     <= load_val[15];
      oe_q       <= 1'b1;
      busy_q     <= 1'b1;
    end else if (abort || release_cs) begin
      miso_q <= 1'b0;
      oe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else if (finish) begin
      miso_q <= 1'b0;
    end else begin
      if (rx_shift_en) begin
        rx_shift_q <= {rx_shift_q[14:0], mosi_s};
        bit_cnt_q  <= bit_cnt_q + 5'd1;
      end
      if (tx_shift_en) begin
        tx_shift_q <= {tx_shift_q[14:0], 1'b0};
        miso_q     <= tx_shift_q[14];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= finish;
      frame_err_q <= abort;
      if (finish) rx_data_q <= rx_shift_q;
    end
  end

  assign miso      = miso_q & oe_q;
  assign miso_oe   = oe_q;
  assign busy      = busy_q;
  assign tx_ready  = ~hold_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_peripheral.sv
// Bench for spi_slave_peripheral: directed scenarios plus randomized frames
// checked against a word-level model of the holding register and frame rules.
module tb_spi_slave_peripheral;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b1;
  logic        cs_bar = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_load = 1'b0;
  logic        miso, miso_oe, tx_ready, rx_valid, frame_err, busy;
  logic [15:0] rx_data;

  int total = 0;
  int bad = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;

  logic        hold_full_m = 1'b0;
  logic [15:0] hold_m = 16'h0000;
  logic [15:0] rx_m = 16'h0000;

  spi_slave_peripheral dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .cs_bar   (cs_bar),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid)  rv_cnt <= rv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // First bit sent is bits[n-1]; miso is captured as the master sees it at each rising edge.
  task automatic sclk_bits(input int n, input logic [31:0] bits, output logic [31:0] so,
                           output logic busy_all, output logic oe_all);
    so = 32'h0;
    busy_all = 1'b1;
    oe_all = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = bits[i];
      wait_clks(5);
      sclk = 1'b1;
      so = {so[30:0], miso};
      busy_all = busy_all & busy;
      oe_all = oe_all & miso_oe;
      wait_clks(5);
    end
  endtask

  task automatic spi_frame(input int n, input logic [31:0] bits, input bit fwd,
                           input logic [15:0] fwd_word, output logic [31:0] so,
                           output logic busy_all, output logic oe_all);
    cs_bar = 1'b0;
    if (fwd) begin
      // tx_load lands on the clk that sees synchronised cs_bar low.
      wait_clks(2);
      tx_data = fwd_word;
      tx_load = 1'b1;
      wait_clks(1);
      tx_load = 1'b0;
      wait_clks(2);
    end else begin
      wait_clks(5);
    end
    sclk_bits(n, bits, so, busy_all, oe_all);
    wait_clks(5);
    cs_bar = 1'b1;
    wait_clks(10);
  endtask

  task automatic do_load(input logic [15:0] w);
    tx_data = w;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
    if (!hold_full_m) begin
      hold_m = w;
      hold_full_m = 1'b1;
    end
  endtask

  // Word the model expects on miso for a frame started now; consumes the holding register.
  task automatic model_start(input bit fwd, input logic [15:0] fwd_word, output logic [15:0] w);
    if (hold_full_m) w = hold_m;
    else if (fwd) w = fwd_word;
    else w = 16'h0000;
    hold_full_m = 1'b0;
  endtask

  function automatic logic [31:0] exp_miso(input logic [15:0] tx, input int n);
    logic [31:0] t;
    t = {16'h0000, tx};
    if (n >= 16) return t << (n - 16);
    return t >> (16 - n);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    wait_clks(3);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", miso); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", miso_oe); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
    total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx_data got=%h want=0000", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b1;
    wait_clks(8);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] so; logic ba, oa; logic [15:0] w; int rv0;
    do_load(16'hA5C3);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_drop got=%b want=0", tx_ready); end
    rv0 = rv_cnt;
    model_start(1'b0, 16'h0, w);
    spi_frame(16, 32'h1234, 1'b0, 16'h0, so, ba, oa);
    rx_m = 16'h1234;
    total++; if (so !== exp_miso(w, 16)) begin bad++; $display("FAIL basic_miso got=%h want=%h", so, exp_miso(w, 16)); end
    total++; if (rx_data !== rx_m) begin bad++; $display("FAIL basic_rx got=%h want=%h", rx_data, rx_m); end
    total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL basic_rx_valid got=%0d want=1", rv_cnt - rv0); end
    total++; if ({ba, oa} !== 2'b11) begin bad++; $display("FAIL basic_busy_oe got=%b want=11", {ba, oa}); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", tx_ready); end
    total++; if ({busy, miso_oe, miso} !== 3'b000) begin bad++; $display("FAIL basic_idle_outs got=%b want=000", {busy, miso_oe, miso}); end
  endtask

  task automatic test_no_load();
    logic [31:0] so; logic ba, oa; logic [15:0] w; int rv0;
    rv0 = rv_cnt;
    model_start(1'b0, 16'h0, w);
    spi_frame(16, 32'h5A0F, 1'b0, 16'h0, so, ba, oa);
    rx_m = 16'h5A0F;
    total++; if (so !== exp_miso(w, 16)) begin bad++; $display("FAIL noload_miso got=%h want=%h", so, exp_miso(w, 16)); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL noload_ready got=%b want=1", tx_ready); end
    total++; if (rx_data !== rx_m) begin bad++; $display("FAIL noload_rx got=%h want=%h", rx_data, rx_m); end
    total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL noload_rx_valid got=%0d want=1", rv_cnt - rv0); end
  endtask

  task automatic test_abort();
    logic [31:0] so; logic ba, oa; logic [15:0] w; int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    model_start(1'b0, 16'h0, w);
    spi_frame(9, 32'h1FF, 1'b0, 16'h0, so, ba, oa);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL abort_frame_err got=%0d want=1", fe_cnt - fe0); end
    total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL abort_rx_valid got=%0d want=0", rv_cnt - rv0); end
    total++; if (rx_data !== rx_m) begin bad++; $display("FAIL abort_rx_kept got=%h want=%h", rx_data, rx_m); end
    total++; if ({busy, miso_oe} !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b want=00", {busy, miso_oe}); end
  endtask

  task automatic test_overlong();
    logic [31:0] so; logic ba, oa; logic [15:0] w; int rv0, fe0;
    do_load(16'h0F0F);
    rv0 = rv_cnt; fe0 = fe_cnt;
    model_start(1'b0, 16'h0, w);
    spi_frame(20, 32'h000BEEFA, 1'b0, 16'h0, so, ba, oa);
    rx_m = 16'hBEEF;
    total++; if (so !== exp_miso(w, 20)) begin bad++; $display("FAIL long_miso got=%h want=%h", so, exp_miso(w, 20)); end
    total++; if (rx_data !== rx_m) begin bad++; $display("FAIL long_rx got=%h want=%h", rx_data, rx_m); end
    total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL long_rx_valid got=%0d want=1", rv_cnt - rv0); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL long_frame_err got=%0d want=0", fe_cnt - fe0); end
    total++; if (ba !== 1'b1) begin bad++; $display("FAIL long_busy got=%b want=1", ba); end
  endtask

  task automatic test_load_ignored();
    logic [31:0] so; logic ba, oa; logic [15:0] w;
    do_load(16'h1111);
    do_load(16'h2222);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL ignore_ready got=%b want=0", tx_ready); end
    model_start(1'b0, 16'h0, w);
    spi_frame(16, 32'hC3C3, 1'b0, 16'h0, so, ba, oa);
    rx_m = 16'hC3C3;
    total++; if (so !== exp_miso(w, 16)) begin bad++; $display("FAIL ignore_miso got=%h want=%h", so, exp_miso(w, 16)); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL ignore_ready_after got=%b want=1", tx_ready); end
  endtask

  task automatic test_forward();
    logic [31:0] so; logic ba, oa; logic [15:0] w;
    model_start(1'b1, 16'h3C96, w);
    spi_frame(16, 32'h0001, 1'b1, 16'h3C96, so, ba, oa);
    rx_m = 16'h0001;
    total++; if (so !== exp_miso(w, 16)) begin bad++; $display("FAIL fwd_empty_miso got=%h want=%h", so, exp_miso(w, 16)); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL fwd_empty_ready got=%b want=1", tx_ready); end
    do_load(16'h7E81);
    model_start(1'b1, 16'h4242, w);
    spi_frame(16, 32'h8000, 1'b1, 16'h4242, so, ba, oa);
    rx_m = 16'h8000;
    total++; if (so !== exp_miso(w, 16)) begin bad++; $display("FAIL fwd_full_miso got=%h want=%h", so, exp_miso(w, 16)); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL fwd_full_ready got=%b want=1", tx_ready); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] so; logic ba, oa; logic [15:0] w; int rv0, fe0;
    do_load(16'h9999);
    rv0 = rv_cnt; fe0 = fe_cnt;
    cs_bar = 1'b0;
    wait_clks(5);
    sclk_bits(8, 32'hA5, so, ba, oa);
    reset = 1'b0;
    #1;
    total++; if ({miso, miso_oe, busy, rx_valid, frame_err} !== 5'b0)
      begin bad++; $display("FAIL midrst_outs got=%b want=00000", {miso, miso_oe, busy, rx_valid, frame_err}); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", tx_ready); end
    total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL midrst_rx got=%h want=0000", rx_data); end
    hold_full_m = 1'b0;
    rx_m = 16'h0000;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(2);
    sclk_bits(8, 32'h5A, so, ba, oa);
    wait_clks(5);
    total++; if ({busy, miso_oe} !== 2'b00) begin bad++; $display("FAIL midrst_ignored got=%b want=00", {busy, miso_oe}); end
    total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d want=0", rv_cnt - rv0); end
    cs_bar = 1'b1;
    wait_clks(10);
    model_start(1'b0, 16'h0, w);
    spi_frame(16, 32'hC0DE, 1'b0, 16'h0, so, ba, oa);
    rx_m = 16'hC0DE;
    total++; if (rx_data !== rx_m) begin bad++; $display("FAIL midrst_next_rx got=%h want=%h", rx_data, rx_m); end
    total++; if (so !== exp_miso(w, 16)) begin bad++; $display("FAIL midrst_next_miso got=%h want=%h", so, exp_miso(w, 16)); end
    total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL midrst_next_valid got=%0d want=1", rv_cnt - rv0); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL midrst_frame_err got=%0d want=0", fe_cnt - fe0); end
  endtask

  task automatic test_random();
    logic [31:0] so, bits; logic ba, oa; logic [15:0] w, fw; int n, rv0, fe0, sel, loads; bit fwd;
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2) n = 16;
      else if (sel == 2) n = $urandom_range(17, 20);
      else n = $urandom_range(1, 15);
      bits = $urandom;
      loads = $urandom_range(0, 2);
      for (int k = 0; k < loads; k++) do_load(16'($urandom));
      total++; if (tx_ready !== !hold_full_m)
        begin bad++; $display("FAIL rand_ready_pre[%0d] got=%b want=%b", it, tx_ready, !hold_full_m); end
      fwd = ($urandom_range(0, 3) == 0);
      fw = 16'($urandom);
      rv0 = rv_cnt; fe0 = fe_cnt;
      model_start(fwd, fw, w);
      spi_frame(n, bits, fwd, fw, so, ba, oa);
      if (n >= 16) rx_m = 16'(bits >> (n - 16));
      total++; if (so !== exp_miso(w, n))
        begin bad++; $display("FAIL rand_miso[%0d] n=%0d got=%h want=%h", it, n, so, exp_miso(w, n)); end
      total++; if (rx_data !== rx_m)
        begin bad++; $display("FAIL rand_rx[%0d] got=%h want=%h", it, rx_data, rx_m); end
      total++; if (rv_cnt - rv0 !== (n >= 16 ? 1 : 0))
        begin bad++; $display("FAIL rand_valid[%0d] got=%0d want=%0d", it, rv_cnt - rv0, n >= 16); end
      total++; if (fe_cnt - fe0 !== (n < 16 ? 1 : 0))
        begin bad++; $display("FAIL rand_err[%0d] got=%0d want=%0d", it, fe_cnt - fe0, n < 16); end
      total++; if (tx_ready !== 1'b1)
        begin bad++; $display("FAIL rand_ready_post[%0d] got=%b want=1", it, tx_ready); end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_no_load();
    test_abort();
    test_overlong();
    test_load_ignored();
    test_forward();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
